// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, constants and the writeback entry type
package cpu_pkg;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_RADDR_W = 5;
  localparam logic [CPU_RADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [CPU_DATA_W-1:0] ZERO_WORD = '0;
  typedef struct packed {
    logic [CPU_DATA_W-1:0] pc;
    logic [CPU_RADDR_W-1:0] rd;
    logic [CPU_DATA_W-1:0] wdata;
    logic wreg;
  } wb_entry_t;
endpackage

// File: rtl/wb_entry_fifo.sv
// wb_entry_fifo: DEPTH-deep FIFO of packed writeback entries with occupancy; WB_RETIRE_FWD_EN exposes all slots
module wb_entry_fifo #(
  parameter int W = 70,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level
`ifdef WB_RETIRE_FWD_EN
  ,
  output logic [DEPTH*W-1:0] slots,
  output logic [AW-1:0]      rd_ptr
`endif
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  // pointers wrap naturally at the power-of-two depth; flush empties the queue
  always_comb begin
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
  end
  // pointer and occupancy state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q <= level_d;
    end
  end
  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end
  assign dout = mem_q[rd_ptr_q];
  assign level = level_q;
`ifdef WB_RETIRE_FWD_EN
  // flatten storage for the forwarding lookup
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slots[i*W +: W] = mem_q[i];
  end
  assign rd_ptr = rd_ptr_q;
`endif
endmodule

// File: rtl/wb_retire_buf.sv
// wb_retire_buf: queued MEM->WB retire stage with empty bypass, hold, flush, x0 suppression and retire counter
// Optional feature macro WB_RETIRE_FWD_EN adds a combinational register-forwarding lookup.
module wb_retire_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int RADDR_W = CPU_RADDR_W,
  parameter int DEPTH = 4,
  parameter int RET_CNT_W = 32,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wb_hold,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_pc,
  input  logic [RADDR_W-1:0]   in_rd,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic                 in_wreg,
  output logic                 wb_valid,
  output logic [DATA_W-1:0]    wb_pc,
  output logic [RADDR_W-1:0]   wb_rd,
  output logic [DATA_W-1:0]    wb_wdata,
  output logic                 wb_wreg,
  output logic [RET_CNT_W-1:0] ret_cnt,
  output logic [LW-1:0]        level
`ifdef WB_RETIRE_FWD_EN
  ,
  input  logic [RADDR_W-1:0]   fwd_raddr,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0] wdata;
    logic wreg;
  } ent_t;
  localparam int EW = $bits(ent_t);
  localparam int AW = LW - 1;
  ent_t in_ent, head, nxt, wb_q, wb_d;
  logic wb_valid_q, wb_valid_d, push, pop, load, fifo_push;
  logic [RET_CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [LW-1:0] lvl;
  assign in_ent = {in_pc, in_rd, in_wdata, in_wreg};
  assign in_ready = (lvl != LW'(DEPTH)) && !flush;
  // retire the FIFO head if any, else bypass a fresh push straight into the output regs
  always_comb begin
    push = in_valid && in_ready;
    pop = (lvl != '0) && !wb_hold && !flush;
    load = pop || ((lvl == '0) && push && !wb_hold);
    fifo_push = push && !(load && !pop);
    nxt = pop ? head : in_ent;
    nxt.wreg = nxt.wreg && (nxt.rd != RADDR_W'(NOP_REG_ADDR));
    wb_d = load ? nxt : wb_q;
    wb_d.wreg = load ? nxt.wreg : wb_q.wreg && wb_hold && !flush;
    wb_valid_d = load || (wb_valid_q && wb_hold && !flush);
    ret_cnt_d = ret_cnt_q + RET_CNT_W'(load);
  end
  // registered retirement outputs and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
      wb_valid_q <= 1'b0;
      ret_cnt_q <= '0;
    end else begin
      wb_q <= wb_d;
      wb_valid_q <= wb_valid_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end
  assign wb_valid = wb_valid_q;
  assign wb_pc = wb_q.pc;
  assign wb_rd = wb_q.rd;
  assign wb_wdata = wb_q.wdata;
  assign wb_wreg = wb_q.wreg;
  assign ret_cnt = ret_cnt_q;
  assign level = lvl;
`ifdef WB_RETIRE_FWD_EN
  logic [DEPTH*EW-1:0] slots;
  logic [AW-1:0] rd_ptr, idx;
  ent_t e;
  // scan oldest to youngest so the youngest match wins; output regs are the oldest
  always_comb begin
    fwd_hit = wb_q.wreg && (wb_q.rd == fwd_raddr) && (fwd_raddr != '0);
    fwd_data = wb_q.wdata;
    idx = '0;
    e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      e = slots[idx*EW +: EW];
      if ((LW'(i) < lvl) && e.wreg && (e.rd != '0) && (e.rd == fwd_raddr)) begin
        fwd_hit = 1'b1;
        fwd_data = e.wdata;
      end
    end
  end
`endif
  wb_entry_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(fifo_push),
    .pop(pop),
    .din(in_ent),
    .dout(head),
    .level(lvl)
`ifdef WB_RETIRE_FWD_EN
    ,
    .slots(slots),
    .rd_ptr(rd_ptr)
`endif
  );
endmodule

// File: tb/tb_wb_retire_buf.sv
// tb_wb_retire_buf: random and directed checks of wb_retire_buf against a queue-based retire model
module tb_wb_retire_buf;
  localparam int DW = 32, RW = 5, DEPTH = 4, CW = 4;
  logic clk = 1'b0;
  logic rst, flush, wb_hold, in_valid, in_ready, in_wreg, wb_valid, wb_wreg;
  logic [DW-1:0] in_pc, in_wdata, wb_pc, wb_wdata;
  logic [RW-1:0] in_rd, wb_rd;
  logic [CW-1:0] ret_cnt;
  logic [2:0] level;
`ifdef WB_RETIRE_FWD_EN
  logic [RW-1:0] fwd_raddr;
  logic fwd_hit;
  logic [DW-1:0] fwd_data;
`endif
  always #5 clk = ~clk;
  wb_retire_buf #(.DATA_W(DW), .RADDR_W(RW), .DEPTH(DEPTH), .RET_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_hold(wb_hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_wdata(in_wdata), .in_wreg(in_wreg), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg), .ret_cnt(ret_cnt),
    .level(level)
`ifdef WB_RETIRE_FWD_EN
    , .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );
  typedef struct {
    logic [DW-1:0] pc;
    logic [RW-1:0] rd;
    logic [DW-1:0] d;
    logic w;
  } ent_t;
  ent_t q[$];
  ent_t m_wb;
  logic m_v = 1'b0;
  int m_cnt = 0;
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic model_step();
    bit rdy, psh;
    ent_t e;
    rdy = (q.size() < DEPTH) && !flush;
    psh = in_valid && rdy;
    e = '{in_pc, in_rd, in_wdata, in_wreg};
    if (rst) begin
      q.delete();
      m_v = 1'b0;
      m_wb = '{0, 0, 0, 0};
      m_cnt = 0;
    end else if (flush) begin
      q.delete();
      m_v = 1'b0;
      m_wb.w = 1'b0;
    end else begin
      if (psh) q.push_back(e);
      if (!wb_hold) begin
        if (q.size() > 0) begin
          m_wb = q.pop_front();
          m_wb.w = m_wb.w && (m_wb.rd != 0);
          m_v = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_v = 1'b0;
          m_wb.w = 1'b0;
        end
      end
    end
  endtask
  task automatic check_comb();
    chk("in_ready", in_ready, (q.size() < DEPTH) && !flush);
`ifdef WB_RETIRE_FWD_EN
    begin
      bit h;
      logic [DW-1:0] d;
      h = m_v && m_wb.w && (m_wb.rd == fwd_raddr) && (fwd_raddr != 0);
      d = m_wb.d;
      foreach (q[i]) if (q[i].w && q[i].rd != 0 && q[i].rd == fwd_raddr) begin
        h = 1'b1;
        d = q[i].d;
      end
      chk("fwd_hit", fwd_hit, h);
      if (h) chk("fwd_data", fwd_data, d);
    end
`endif
  endtask
  task automatic check_out();
    chk("wb_valid", wb_valid, m_v);
    chk("wb_wreg", wb_wreg, m_wb.w);
    chk("level", level, q.size());
    chk("ret_cnt", ret_cnt, m_cnt);
    if (m_v) begin
      chk("wb_pc", wb_pc, m_wb.pc);
      chk("wb_rd", wb_rd, m_wb.rd);
      chk("wb_wdata", wb_wdata, m_wb.d);
    end
  endtask
  task automatic cyc(input bit v, input bit h, input bit f, input logic [RW-1:0] rd, input logic [DW-1:0] d, input bit w);
    in_valid = v;
    wb_hold = h;
    flush = f;
    in_rd = rd;
    in_wdata = d;
    in_wreg = w;
    in_pc = $urandom;
`ifdef WB_RETIRE_FWD_EN
    fwd_raddr = RW'($urandom_range(0, 7));
`endif
    #1;
    if (!rst) check_comb();
    @(posedge clk);
    model_step();
    #1;
    check_out();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_wreg", wb_wreg, 0);
    chk("rst wb_pc", wb_pc, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_wdata", wb_wdata, 0);
    chk("rst ret_cnt", ret_cnt, 0);
    chk("rst level", level, 0);
    cyc(1, 0, 0, 5, 32'hDEADBEEF, 1);
    chk("t1 wb_valid", wb_valid, 1);
    chk("t1 wb_rd", wb_rd, 5);
    chk("t1 wb_wdata", wb_wdata, 32'hDEADBEEF);
    chk("t1 wb_wreg", wb_wreg, 1);
    chk("t1 ret_cnt", ret_cnt, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1 idle valid", wb_valid, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, RW'(i + 1), DW'(i + 16), 1);
    chk("t2 level full", level, 4);
    chk("t2 ready low", in_ready, 0);
    cyc(1, 1, 0, 9, 32'h99, 1);
    chk("t2 level held", level, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("t2 drain valid", wb_valid, 1);
      chk("t2 drain rd", wb_rd, i + 1);
      chk("t2 drain data", wb_wdata, i + 16);
    end
    chk("t2 ret_cnt", ret_cnt, 4);
    cyc(1, 0, 0, 0, 32'h1234, 1);
    chk("t3 wb_valid", wb_valid, 1);
    chk("t3 wb_wreg", wb_wreg, 0);
    chk("t3 ret_cnt", ret_cnt, 5);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, RW'(i + 2), DW'(i), 1);
    chk("t4 level", level, 3);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("t4 flush ready", in_ready, 0);
    cyc(1, 0, 1, 3, 3, 1);
    chk("t4 level", level, 0);
    chk("t4 wb_valid", wb_valid, 0);
    chk("t4 ret_cnt", ret_cnt, 5);
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, RW'(i), DW'(i), 1);
    chk("t5 ret_cnt wrap", ret_cnt, 1);
`ifdef WB_RETIRE_FWD_EN
    do_reset();
    cyc(1, 1, 0, 7, 32'hA, 1);
    cyc(1, 1, 0, 7, 32'hB, 1);
    in_valid = 1'b0;
    fwd_raddr = 7;
    #1;
    chk("t6 fwd hit", fwd_hit, 1);
    chk("t6 fwd data", fwd_data, 32'hB);
    fwd_raddr = 0;
    #1;
    chk("t6 fwd x0", fwd_hit, 0);
`endif
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
          RW'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
